wb_io_regs: RTL

- Pipelined Wishbone B4 responder for the 0xc0000000 IO region; it answers the CPU core's requests (cyc/stb/stall/ack handshake) once the top-level address decode has selected the IO region.
- Provides a small register bank:
  - ID
  - SCRATCH
  - LED output
  - free-running TIMER
  - TIMER compare with sticky match flag and interrupt
- Responses are in-order, with a fixed LATENCY and a bounded number of outstanding requests.

---
 rtl/wb_io_regs.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_io_regs.sv
// wb_io_regs: pipelined Wishbone B4 responder for the IO region.
// Register bank: ID, SCRATCH, LED, free-running TIMER, CMP, and CTRL/STATUS.
// Each accepted request gets exactly one in-order ack or err, LATENCY cycles
// after it is accepted.
// Optional macro WB_IO_SEL_EN adds the i_wb_sel byte-lane write enables.
// Without it, every write is a full 32-bit word.
module wb_io_regs #(
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] ID_VALUE        = 32'h56474101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
`ifdef WB_IO_SEL_EN
    input  logic [3:0]  i_wb_sel,
`endif
    output logic [31:0] o_data,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [7:0]  o_led,
    output logic        o_irq
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    // Expand byte-lane selects into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // Replace only the masked bits of old_v with new_v.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic [3:0]  sel_s;
    logic [31:0] mask_s;
    logic [2:0]  idx_s;
    logic        acc_s;
    logic        wr_s;
    logic        retire_s;
    logic        unmapped_s;
    logic [31:0] rdata_s;
    logic        wr_scr_s, wr_led_s, wr_tmr_s, wr_cmp_s, wr_ctl_s;
    logic        unused_s;

    logic [31:0] scratch_r;
    logic [7:0]  led_r;
    logic [31:0] timer_r;
    logic [31:0] cmp_r;
    logic        timer_en_r;
    logic        irq_en_r;
    logic        match_r;
    logic [3:0]  cnt_r;

    logic [LATENCY-1:0] pv_r;
    logic [LATENCY-1:0] pe_r;
    logic [31:0]        pd_r [LATENCY];

`ifdef WB_IO_SEL_EN
    assign sel_s = i_wb_sel;
`else
    assign sel_s = 4'hF;
`endif

    assign mask_s     = lane_mask(sel_s);
    assign idx_s      = i_addr[4:2];
    assign retire_s   = pv_r[LATENCY-1];
    // A response leaving the pipe this cycle frees its slot immediately.
    assign o_wb_stall = (cnt_r == MAX_CNT) && !retire_s;
    assign acc_s      = i_wb_cyc & i_wb_stb & i_enable & ~o_wb_stall;
    assign wr_s       = acc_s & i_we;
    assign unused_s   = ^{i_addr[31:5], i_addr[1:0]};

    // Address decode: read mux, per-register write strobes, and unmapped flag.
    always_comb begin
        rdata_s    = 32'h0;
        unmapped_s = 1'b0;
        wr_scr_s   = 1'b0;
        wr_led_s   = 1'b0;
        wr_tmr_s   = 1'b0;
        wr_cmp_s   = 1'b0;
        wr_ctl_s   = 1'b0;
        case (idx_s)
            3'd0: rdata_s = ID_VALUE;
            3'd1: begin
                rdata_s  = scratch_r;
                wr_scr_s = wr_s;
            end
            3'd2: begin
                rdata_s  = {24'h0, led_r};
                wr_led_s = wr_s;
            end
            3'd3: begin
                rdata_s  = timer_r;
                wr_tmr_s = wr_s;
            end
            3'd4: begin
                rdata_s  = cmp_r;
                wr_cmp_s = wr_s;
            end
            3'd5: begin
                rdata_s  = {23'h0, match_r, 6'h0, irq_en_r, timer_en_r};
                wr_ctl_s = wr_s;
            end
            default: unmapped_s = 1'b1;
        endcase
    end

    // Software-visible registers; writes commit on the acceptance edge.
    // When a match and a clear of the match flag land on the same edge, the match wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch_r  <= 32'h0;
            led_r      <= 8'h0;
            cmp_r      <= 32'h0;
            timer_en_r <= 1'b0;
            irq_en_r   <= 1'b0;
            match_r    <= 1'b0;
        end else begin
            if (wr_scr_s) begin
                scratch_r <= merge_lanes(scratch_r, i_data, mask_s);
            end
            if (wr_led_s && sel_s[0]) begin
                led_r <= i_data[7:0];
            end
            if (wr_cmp_s) begin
                cmp_r <= merge_lanes(cmp_r, i_data, mask_s);
            end
            if (wr_ctl_s && sel_s[0]) begin
                timer_en_r <= i_data[0];
                irq_en_r   <= i_data[1];
            end
            if (timer_en_r && (timer_r == cmp_r)) begin
                match_r <= 1'b1;
            end else if (wr_ctl_s && sel_s[1] && i_data[8]) begin
                match_r <= 1'b0;
            end
        end
    end

    // Free-running timer; a software clear beats the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= 32'h0;
        end else if (wr_tmr_s && (|sel_s)) begin
            timer_r <= 32'h0;
        end else if (timer_en_r) begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Outstanding-request counter; dropping cyc forgets everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (!i_wb_cyc) begin
            cnt_r <= 4'd0;
        end else if (acc_s && !retire_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else if (!acc_s && retire_s) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response shift pipe of {valid, err, data}; read data is captured at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_r <= '0;
            pe_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd_r[i] <= 32'h0;
            end
        end else begin
            pv_r[0] <= acc_s;
            pe_r[0] <= unmapped_s;
            pd_r[0] <= (i_we || unmapped_s) ? 32'h0 : rdata_s;
            for (int i = 1; i < LATENCY; i++) begin
                pv_r[i] <= i_wb_cyc ? pv_r[i-1] : 1'b0;
                pe_r[i] <= pe_r[i-1];
                pd_r[i] <= pd_r[i-1];
            end
            if (!i_wb_cyc) begin
                pv_r[0] <= 1'b0;
            end
        end
    end

    // Responses are suppressed in any cycle where the master has dropped cyc.
    assign o_wb_ack = pv_r[LATENCY-1] & ~pe_r[LATENCY-1] & i_wb_cyc;
    assign o_wb_err = pv_r[LATENCY-1] &  pe_r[LATENCY-1] & i_wb_cyc;
    assign o_data   = o_wb_ack ? pd_r[LATENCY-1] : 32'h0;
    assign o_led    = led_r;
    assign o_irq    = match_r & irq_en_r;

endmodule
